// File: rtl/program_sequencer.sv
// Instruction-issue front end: loadable program memory, fetch/exec handshake
// with the core over instruction/run/done, and a per-instruction watchdog.
module program_sequencer #(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int MAX_WAIT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_valid,
  input  logic [AW-1:0] load_addr,
  input  logic [15:0]   load_data,
  output logic          load_ready,
  input  logic          start,
  input  logic [AW:0]   prog_len,
  output logic [15:0]   instruction,
  output logic          run,
  input  logic          done,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          finished,
  output logic          error
);

  localparam int WW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC,
    FINISH,
    ERROR
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] pc_q, pc_n;
  logic [AW:0]   len_q, len_n;
  logic [WW-1:0] wait_q, wait_n;
  logic [15:0]   instr_q, instr_n;
  logic [AW:0]   len_clamped;
  logic [AW:0]   pc_plus1;

  logic [15:0] mem [DEPTH];

  // Program memory is deliberately left out of reset so a program survives it.
  always_ff @(posedge clk) begin
    if (load_valid && state == IDLE) begin
      mem[load_addr] <= load_data;
    end
  end

  assign len_clamped = (prog_len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : prog_len;
  assign pc_plus1    = {1'b0, pc_q} + (AW+1)'(1);

  always_comb begin
    state_n = state;
    pc_n    = pc_q;
    len_n   = len_q;
    wait_n  = wait_q;
    instr_n = instr_q;
    unique case (state)
      IDLE, ERROR: begin
        if (start) begin
          if (prog_len == '0) begin
            state_n = FINISH;
          end else begin
            len_n   = len_clamped;
            pc_n    = '0;
            state_n = FETCH;
          end
        end
      end
      FETCH: begin
        instr_n = mem[pc_q];
        wait_n  = '0;
        state_n = EXEC;
      end
      EXEC: begin
        // A done arriving on the last allowed cycle still counts as success.
        if (done) begin
          if (pc_plus1 == len_q) begin
            state_n = FINISH;
          end else begin
            pc_n    = pc_q + AW'(1);
            state_n = FETCH;
          end
        end else if (wait_q == WW'(MAX_WAIT - 1)) begin
          state_n = ERROR;
        end else begin
          wait_n = wait_q + WW'(1);
        end
      end
      FINISH: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      wait_q  <= '0;
      instr_q <= '0;
    end else begin
      state   <= state_n;
      pc_q    <= pc_n;
      len_q   <= len_n;
      wait_q  <= wait_n;
      instr_q <= instr_n;
    end
  end

  assign instruction = instr_q;
  assign pc          = pc_q;
  assign run         = (state == EXEC);
  assign busy        = (state == FETCH) || (state == EXEC);
  assign finished    = (state == FINISH);
  assign error       = (state == ERROR);
  assign load_ready  = (state == IDLE);

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: stimulus queues expected issue,
// finish and error events; a negedge monitor pops and compares them.
module tb_program_sequencer;

  localparam int DEPTH    = 16;
  localparam int AW       = 4;
  localparam int MAX_WAIT = 15;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_valid;
  logic [AW-1:0] load_addr;
  logic [15:0]   load_data;
  logic          load_ready;
  logic          start;
  logic [AW:0]   prog_len;
  logic [15:0]   instruction;
  logic          run;
  logic          done;
  logic [AW-1:0] pc;
  logic          busy;
  logic          finished;
  logic          error;

  program_sequencer #(.DEPTH(DEPTH), .AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
    .load_ready(load_ready), .start(start), .prog_len(prog_len),
    .instruction(instruction), .run(run), .done(done), .pc(pc),
    .busy(busy), .finished(finished), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 issue, 1 finish, 2 error
    int          cyc;
    logic [AW-1:0] pc;
    logic [15:0] instr;
  } ev_t;

  ev_t         exp_q[$];
  logic [15:0] shadow [DEPTH];
  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;
  int          lat   = 1;
  bit          hang  = 1'b0;
  int          exec_cnt = 0;
  bit          prev_run = 1'b0;
  bit          prev_err = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Core model: raises done in the lat-th EXEC cycle unless told to hang.
  always @(negedge clk) begin
    if (run) begin
      exec_cnt = exec_cnt + 1;
      done = !hang && (exec_cnt == lat);
    end else begin
      exec_cnt = 0;
      done = 1'b0;
    end
  end

  task automatic handle_event(input int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL unexpected_event: got kind %0d at cycle %0d, expected none", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      check_output("event_kind", kind, e.kind);
      check_output("event_cycle", cyc, e.cyc);
      if (kind == 0) begin
        check_output("issue_instr", {16'h0, instruction}, {16'h0, e.instr});
        check_output("issue_pc", {28'h0, pc}, {28'h0, e.pc});
      end else if (kind == 2) begin
        check_output("error_pc", {28'h0, pc}, {28'h0, e.pc});
        check_output("error_run", {31'h0, run}, 32'h0);
      end
    end
  endtask

  // Monitor: an issue is a rising run, plus finish pulses and rising error.
  always @(negedge clk) begin
    if (run && !prev_run) handle_event(0);
    if (finished) handle_event(1);
    if (error && !prev_err) handle_event(2);
    if (exp_q.size() > 0 && cyc > exp_q[0].cyc + 4) begin
      tests++;
      fails++;
      $display("[TB] FAIL missed_event: got nothing by cycle %0d, expected kind %0d at cycle %0d",
               cyc, exp_q[0].kind, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    prev_run = run;
    prev_err = error;
  end

  task automatic check_reset_values();
    check_output("rst_instruction", {16'h0, instruction}, 32'h0);
    check_output("rst_run", {31'h0, run}, 32'h0);
    check_output("rst_pc", {28'h0, pc}, 32'h0);
    check_output("rst_busy", {31'h0, busy}, 32'h0);
    check_output("rst_finished", {31'h0, finished}, 32'h0);
    check_output("rst_error", {31'h0, error}, 32'h0);
    check_output("rst_load_ready", {31'h0, load_ready}, 32'h1);
  endtask

  task automatic load_word(input int a, input logic [15:0] d, input bit accepted);
    @(negedge clk);
    load_valid = 1'b1;
    load_addr  = AW'(a);
    load_data  = d;
    if (accepted) shadow[a] = d;
    @(negedge clk);
    load_valid = 1'b0;
  endtask

  // Issues start and queues push_n issue events, optionally the finish pulse.
  task automatic apply_stimulus(input int n, input int l, input int push_n, input bit push_fin,
                                input bit with_load, input int a, input logic [15:0] d,
                                output int s);
    int   eff;
    ev_t  e;
    @(negedge clk);
    start    = 1'b1;
    prog_len = (AW+1)'(n);
    lat      = l;
    if (with_load) begin
      load_valid = 1'b1;
      load_addr  = AW'(a);
      load_data  = d;
      shadow[a]  = d;
    end
    s   = cyc + 1;
    eff = (n > DEPTH) ? DEPTH : n;
    for (int i = 0; i < push_n; i++) begin
      e.kind = 0; e.cyc = s + 1 + i * (l + 1); e.pc = AW'(i); e.instr = shadow[i];
      exp_q.push_back(e);
    end
    if (push_fin) begin
      e.kind = 1; e.cyc = s + eff * (l + 1); e.pc = '0; e.instr = '0;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start      = 1'b0;
    load_valid = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    for (int i = 0; i < limit; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL drain_timeout: got %0d pending events, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no completion, expected $finish");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    int  s;
    ev_t e;
    reset = 1'b1; load_valid = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; prog_len = '0; done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    reset = 1'b0;

    load_word(0, 16'h2405, 1'b1);
    load_word(1, 16'h4809, 1'b1);
    load_word(2, 16'h6C01, 1'b1);
    for (int i = 3; i < DEPTH; i++) load_word(i, 16'(i * 16'h1111), 1'b1);

    // Basic program, with a write attempted while busy.
    apply_stimulus(3, 1, 3, 1'b1, 1'b0, 0, 16'h0, s);
    load_valid = 1'b1; load_addr = AW'(1); load_data = 16'hFFFF;
    check_output("gate_load_ready", {31'h0, load_ready}, 32'h0);
    check_output("gate_busy", {31'h0, busy}, 32'h1);
    @(negedge clk);
    load_valid = 1'b0;
    wait_drain(50);
    check_output("basic_final_pc", {28'h0, pc}, 32'h2);

    // Zero-length program.
    apply_stimulus(0, 1, 0, 1'b1, 1'b0, 0, 16'h0, s);
    check_output("zero_busy0", {31'h0, busy}, 32'h0);
    check_output("zero_run0", {31'h0, run}, 32'h0);
    @(negedge clk);
    check_output("zero_busy1", {31'h0, busy}, 32'h0);
    check_output("zero_load_ready", {31'h0, load_ready}, 32'h1);

    // The write attempted while busy must not have landed.
    apply_stimulus(2, 2, 2, 1'b1, 1'b0, 0, 16'h0, s);
    wait_drain(50);

    // Watchdog timeout, then restart out of ERROR.
    hang = 1'b1;
    apply_stimulus(1, 1, 1, 1'b0, 1'b0, 0, 16'h0, s);
    e.kind = 2; e.cyc = s + MAX_WAIT + 1; e.pc = '0; e.instr = '0;
    exp_q.push_back(e);
    wait_drain(60);
    check_output("err_flag", {31'h0, error}, 32'h1);
    check_output("err_run", {31'h0, run}, 32'h0);
    check_output("err_pc", {28'h0, pc}, 32'h0);
    check_output("err_load_ready", {31'h0, load_ready}, 32'h0);
    load_word(0, 16'h1234, 1'b0);
    check_output("err_sticky", {31'h0, error}, 32'h1);
    hang = 1'b0;
    apply_stimulus(1, 1, 1, 1'b1, 1'b0, 0, 16'h0, s);
    check_output("err_cleared", {31'h0, error}, 32'h0);
    wait_drain(50);

    // Over-long prog_len clamps to DEPTH.
    apply_stimulus(DEPTH + 4, 1, DEPTH, 1'b1, 1'b0, 0, 16'h0, s);
    wait_drain(120);
    check_output("clamp_final_pc", {28'h0, pc}, 32'(DEPTH - 1));

    // Load and start in the same IDLE cycle.
    apply_stimulus(1, 1, 1, 1'b1, 1'b1, 0, 16'hABCD, s);
    wait_drain(50);

    // Reset during EXEC of the second instruction.
    apply_stimulus(3, 3, 2, 1'b0, 1'b0, 0, 16'h0, s);
    for (int i = 0; i < 40; i++) begin
      if (run && pc == AW'(1)) break;
      @(negedge clk);
    end
    check_output("mid_reset_reached", {31'h0, run && pc == AW'(1)}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset_values();
    check_output("mid_reset_pending", exp_q.size(), 32'h0);
    exp_q.delete();
    reset = 1'b0;

    apply_stimulus(3, 1, 3, 1'b1, 1'b0, 0, 16'h0, s);
    wait_drain(50);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
# program_sequencer

Instruction-issue front end for the 16-bit processor core. Holds a small loadable program memory, fetches one 16-bit instruction at a time, and presents it to the core with `run` held high. It advances only after the core reports `done`, and a watchdog aborts the sequence if `done` never arrives. It is the driving end of the core's `instruction`/`run`/`done` interface.

## Interface
- `DEPTH`, default 16: number of program words.
- `AW`, default 4: address width, equal to log2(`DEPTH`).
- `MAX_WAIT`, default 15: maximum number of EXEC cycles allowed per instruction before timeout. Must be at least 1.
- `clk`  in  1: single clock, rising-edge.
- `reset`  in  1: synchronous, active-high reset.
- `load_valid`  in  1: program-memory write strobe.
- `load_addr`  in  AW: program-memory write address.
- `load_data`  in  16: instruction word to write.
- `load_ready`  out  1: high when writes are accepted (IDLE state only).
- `start`  in  1: begin executing the program; sampled only in IDLE or ERROR.
- `prog_len`  in  AW+1: number of instructions, 0..DEPTH; latched on an accepted `start`.
- `instruction`  out  16: current instruction to the core.
- `run`  out  1: instruction valid, core enabled.
- `done`  in  1: core completed the current instruction.
- `pc`  out  AW: index of the current instruction.
- `busy`  out  1: high in FETCH and EXEC.
- `finished`  out  1: one-cycle pulse when the program completes.
- `error`  out  1: timeout flag; sticky until reset or the next accepted `start`.

## Operation
- **States:** IDLE, FETCH, EXEC, FINISH, ERROR. Reset state is IDLE.
- **Memory:**
  - `DEPTH` x 16 bits, with a synchronous write and a registered read.
  - Contents are not cleared by reset.
  - A write occurs when `load_valid` is high and the state is IDLE. Writes outside IDLE are dropped silently.
- **IDLE:**
  - `start` with `prog_len`=0 goes to FINISH.
  - `start` with `prog_len` greater than 0 latches the length, sets `pc` to 0, and goes to FETCH.
  - A `prog_len` greater than `DEPTH` is clamped to `DEPTH`.
- **FETCH:** `instruction` is loaded from mem[`pc`], `wait_cnt` is cleared, and the state moves to EXEC. `run` is 0 in this state.
- **EXEC:**
  - `run` is 1 and `instruction` is held stable.
  - On `done`=1: if `pc`+1 equals the latched length, go to FINISH with `pc` unchanged. Otherwise increment `pc` and go to FETCH.
  - On `done`=0: increment `wait_cnt`. If `wait_cnt` equals `MAX_WAIT`-1, go to ERROR.
  - If `done` and timeout occur in the same cycle, `done` wins.
- **FINISH:** assert `finished` for one cycle, then go to IDLE.
- **ERROR:**
  - `error` is 1 and `run` is 0. `pc` holds the index of the faulting instruction.
  - `start` clears `error` and restarts exactly as from IDLE.
  - Loads are not accepted in ERROR.
- **Combinational outputs:** `busy` = FETCH or EXEC; `load_ready` = IDLE.
- **Ignored inputs:**
  - `start` is ignored in FETCH, EXEC and FINISH.
  - `done` is ignored outside EXEC.
- **Simultaneous events:** `load_valid` and `start` in the same IDLE cycle are both accepted. The write is visible to the FETCH that follows.
- **Reset mid-operation:** the next edge returns all outputs to their reset values and drops `run` immediately. The memory is retained.

## Timing
- **Reset values:** `instruction`=0, `run`=0, `pc`=0, `busy`=0, `finished`=0, `error`=0, `load_ready`=1.
- **Start to first issue:** `start` sampled at edge N puts FETCH in cycle N+1. EXEC begins in cycle N+2, with `run`=1 and `instruction`=mem[0].
- **Per-instruction cost:** 1 FETCH cycle plus k EXEC cycles, where `done` is sampled in the k-th EXEC cycle. Minimum is 2 cycles per instruction. `run` drops for exactly one cycle between instructions.
- **Finish pulse:** `finished` goes high in the cycle after the final `done` is sampled.
- **Timeout:** after `MAX_WAIT` consecutive EXEC cycles without `done`, `error` rises in the next cycle.
- **Write latency:** a write at edge N is readable by a FETCH at edge N+1 or later.

## Test plan
- **Basic program:** load mem[0..2] with 16'h2405, 16'h4809 and 16'h6C01. Start with `prog_len`=3, and the core model asserts `done` in the first EXEC cycle. Expect `run` high in cycles 2, 4 and 6 with those three words in order, `pc` values 0, 1, 2, and `finished` in cycle 7.
- **Zero-length program:** `start` with `prog_len`=0. Expect `finished` in the next cycle, `run` never high, and `busy` never high.
- **Timeout:** use `MAX_WAIT`=15 and hold `done` low. Expect `run` high for exactly 15 cycles, then `error`=1, `run`=0 and `pc`=0. A following `start` must clear `error` and reissue mem[0].
- **Load gating:** attempt `load_valid` writing 16'hFFFF to addr 1 while `busy`. Expect `load_ready`=0, and a later run still issues the original mem[1].
- **Simultaneous load and start:** in the same IDLE cycle, write 16'hABCD to addr 0 and `start` with `prog_len`=1. Expect `instruction`=16'hABCD in the first EXEC cycle.
- **Reset mid-operation:** assert `reset` during EXEC of instruction 2. The next cycle must show all outputs at reset values, and a restart must reproduce the stored program.
